// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the E stage of the MIPS pipeline.
// The result is computed at the accepting edge into shadow registers.
// It is then committed to HI/LO once a fixed busy window has elapsed,
// so the pipeline sees the multi-cycle latency of the real instructions.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        flush,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   shadow_hi_q;
    logic [31:0]   shadow_lo_q;
    logic          div_zero_q;

    // Next-shadow values computed from the operands present at the accepting edge
    logic [31:0]   shadow_hi_d;
    logic [31:0]   shadow_lo_d;
    logic          div_zero_d;
    logic [CW-1:0] cnt_d;

    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic [31:0]   divisor_safe;
    logic [31:0]   dividend_mag;
    logic [31:0]   divisor_mag;
    logic [31:0]   quot_mag;
    logic [31:0]   rem_mag;
    logic [31:0]   quot_u;
    logic [31:0]   rem_u;

    logic          accept_start;
    logic          accept_mt;

    assign accept_start = (state_q == IDLE) && start && !flush &&
                          (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign accept_mt    = (state_q == IDLE) && !flush &&
                          ((md_op == OP_MTHI) || (md_op == OP_MTLO));

    // Arithmetic datapath: sign-extended 64-bit products and magnitude-based division
    always_comb begin
        // Low 64 bits of the product of sign-extended operands equal the signed product.
        prod_s       = {{32{D1[31]}}, D1} * {{32{D2[31]}}, D2};
        prod_u       = {32'b0, D1} * {32'b0, D2};

        // A zero divisor is replaced by 1 so the divider never sees 0;
        // the result is discarded anyway via the divide-by-zero flag.
        divisor_safe = (D2 == 32'd0) ? 32'd1 : D2;

        // Signed division via magnitudes: -2^31 has magnitude 0x80000000 as unsigned,
        // which makes -2^31 / -1 wrap naturally to 0x80000000 with remainder 0.
        dividend_mag = D1[31] ? (32'd0 - D1) : D1;
        divisor_mag  = divisor_safe[31] ? (32'd0 - divisor_safe) : divisor_safe;
        quot_mag     = dividend_mag / divisor_mag;
        rem_mag      = dividend_mag % divisor_mag;

        quot_u       = D1 / divisor_safe;
        rem_u        = D1 % divisor_safe;

        shadow_hi_d  = 32'd0;
        shadow_lo_d  = 32'd0;
        div_zero_d   = 1'b0;
        cnt_d        = CW'(MULT_CYCLES);
        case (md_op)
            OP_MULT: begin
                shadow_hi_d = prod_s[63:32];
                shadow_lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
                shadow_hi_d = prod_u[63:32];
                shadow_lo_d = prod_u[31:0];
            end
            OP_DIV: begin
                // Quotient truncates toward zero; remainder takes the dividend's sign.
                shadow_lo_d = (D1[31] ^ divisor_safe[31]) ? (32'd0 - quot_mag) : quot_mag;
                shadow_hi_d = D1[31] ? (32'd0 - rem_mag) : rem_mag;
                div_zero_d  = (D2 == 32'd0);
                cnt_d       = CW'(DIV_CYCLES);
            end
            OP_DIVU: begin
                shadow_lo_d = quot_u;
                shadow_hi_d = rem_u;
                div_zero_d  = (D2 == 32'd0);
                cnt_d       = CW'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    // Control FSM, countdown, shadow capture and HI/LO commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            shadow_hi_q <= 32'd0;
            shadow_lo_q <= 32'd0;
            div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_start) begin
                        shadow_hi_q <= shadow_hi_d;
                        shadow_lo_q <= shadow_lo_d;
                        div_zero_q  <= div_zero_d;
                        cnt_q       <= cnt_d;
                        busy_q      <= 1'b1;
                        state_q     <= RUN;
                    end else if (accept_mt) begin
                        if (md_op == OP_MTHI) begin
                            hi_q <= D1;
                        end else begin
                            lo_q <= D1;
                        end
                    end
                end
                RUN: begin
                    // Requests arriving here are ignored; the hazard unit holds them in D.
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (!div_zero_q) begin
                            hi_q <= shadow_hi_q;
                            lo_q <= shadow_lo_q;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed and random mult/div/mt operations
// compared against a longint-arithmetic reference of the architectural HI/LO.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic        flush;
    logic [31:0] D1;
    logic [31:0] D2;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ref_hi   = 32'd0;
    logic [31:0] ref_lo   = 32'd0;

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .md_op(md_op),
        .flush(flush),
        .D1   (D1),
        .D2   (D2),
        .Busy (Busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 clk = ~clk;

    // Reference model: architectural effect of one accepted operation
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p, q, r;
        longint unsigned pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = sa * sb; ref_hi = p[63:32]; ref_lo = p[31:0]; end
            3'd2: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                ref_hi = pu[63:32]; ref_lo = pu[31:0];
            end
            3'd3: if (b != 32'd0) begin
                q = sa / sb; r = sa % sb;
                ref_lo = q[31:0]; ref_hi = r[31:0];
            end
            3'd4: if (b != 32'd0) begin ref_lo = a / b; ref_hi = a % b; end
            3'd5: ref_hi = a;
            3'd6: ref_lo = a;
            default: ;
        endcase
    endtask

    function automatic int exp_cycles(input logic [2:0] op);
        return (op <= 3'd2) ? 5 : 10;
    endfunction

    // Issue one mult/div from a negedge and measure the busy window.
    // held reports whether HI/LO kept their pre-start values while Busy was high.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cnt, output bit held);
        logic [31:0] h0, l0;
        h0 = HI; l0 = LO; held = 1'b1; cnt = 0;
        start = 1'b1; md_op = op; D1 = a; D2 = b; flush = 1'b0;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0; D1 = $urandom; D2 = $urandom;
        while (Busy && cnt < 40) begin
            cnt++;
            if (HI !== h0 || LO !== l0) held = 1'b0;
            @(negedge clk);
        end
        $display("op=%0d D1=%08h D2=%08h busy_cycles=%0d HI=%08h LO=%08h", op, a, b, cnt, HI, LO);
    endtask

    // Issue one mthi/mtlo (or a no-op with flush) from a negedge
    task automatic mt_op(input logic [2:0] op, input logic [31:0] v, input logic fl);
        md_op = op; D1 = v; flush = fl; start = 1'b0;
        @(negedge clk);
        md_op = 3'd0; flush = 1'b0; D1 = $urandom;
        $display("mt op=%0d D1=%08h flush=%0d HI=%08h LO=%08h Busy=%0d", op, v, fl, HI, LO, Busy);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; md_op = 3'd0; flush = 1'b0; D1 = '0; D2 = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: Busy=%0d HI=%08h LO=%08h required 0/0/0", Busy, HI, LO);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: Busy=%0d HI=%08h LO=%08h required 0/0/0", Busy, HI, LO);
        end
    endtask

    // Directed then random operands for one arithmetic op code
    task automatic test_arith(input logic [2:0] op, input logic [31:0] a0, input logic [31:0] b0,
                              input int n_rand);
        int cnt; bit held; logic [31:0] a, b;
        for (int i = 0; i <= n_rand; i++) begin
            a = (i == 0) ? a0 : $urandom;
            b = (i == 0) ? b0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            if (b == 32'd0) b = 32'd3;
            run_op(op, a, b, cnt, held);
            model_apply(op, a, b);
            n_checks++;
            if (cnt != exp_cycles(op)) begin
                n_fail++;
                $display("FAIL busy_len op%0d: %0d cycles required %0d", op, cnt, exp_cycles(op));
            end
            n_checks++;
            if (!held) begin
                n_fail++;
                $display("FAIL early_commit op%0d: HI/LO changed while Busy, required unchanged", op);
            end
            n_checks++;
            if (HI !== ref_hi || LO !== ref_lo) begin
                n_fail++;
                $display("FAIL result op%0d a=%08h b=%08h: HI=%08h LO=%08h required HI=%08h LO=%08h",
                         op, a, b, HI, LO, ref_hi, ref_lo);
            end
        end
    endtask

    task automatic test_div_zero();
        int cnt; bit held;
        mt_op(3'd6, 32'h1234, 1'b0); model_apply(3'd6, 32'h1234, 32'd0);
        n_checks++;
        if (LO !== 32'h1234 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo: LO=%08h Busy=%0d required 00001234/0", LO, Busy);
        end
        mt_op(3'd5, 32'h5678, 1'b0); model_apply(3'd5, 32'h5678, 32'd0);
        n_checks++;
        if (HI !== 32'h5678 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi: HI=%08h Busy=%0d required 00005678/0", HI, Busy);
        end
        run_op(3'd3, 32'd99, 32'd0, cnt, held);
        n_checks++;
        if (cnt != 10 || HI !== 32'h5678 || LO !== 32'h1234) begin
            n_fail++;
            $display("FAIL div_by_zero: cycles=%0d HI=%08h LO=%08h required 10/00005678/00001234", cnt, HI, LO);
        end
        run_op(3'd4, 32'd99, 32'd0, cnt, held);
        n_checks++;
        if (cnt != 10 || HI !== 32'h5678 || LO !== 32'h1234) begin
            n_fail++;
            $display("FAIL divu_by_zero: cycles=%0d HI=%08h LO=%08h required 10/00005678/00001234", cnt, HI, LO);
        end
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cnt, held);
        model_apply(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        n_checks++;
        if (HI !== ref_hi || LO !== ref_lo) begin
            n_fail++;
            $display("FAIL div_overflow: HI=%08h LO=%08h required HI=%08h LO=%08h", HI, LO, ref_hi, ref_lo);
        end
    endtask

    task automatic test_flush();
        start = 1'b1; md_op = 3'd1; D1 = 32'd7; D2 = 32'd9; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0; flush = 1'b0;
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_start: Busy=%0d required 0", Busy);
        end
        mt_op(3'd5, 32'hDEAD_BEEF, 1'b1);
        n_checks++;
        if (HI !== ref_hi || LO !== ref_lo || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_mthi: HI=%08h LO=%08h Busy=%0d required HI=%08h LO=%08h Busy=0",
                     HI, LO, Busy, ref_hi, ref_lo);
        end
    endtask

    task automatic test_ignore_run();
        int cnt = 0;
        start = 1'b1; md_op = 3'd2; D1 = 32'hFFFF_FFFF; D2 = 32'd2; flush = 1'b0;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        while (Busy && cnt < 40) begin
            cnt++;
            if (cnt == 2) begin start = 1'b1; md_op = 3'd3; D1 = 32'd100; D2 = 32'd7; end
            else if (cnt == 3) begin start = 1'b0; md_op = 3'd5; D1 = 32'hAAAA_5555; end
            else begin start = 1'b0; md_op = 3'd0; end
            @(negedge clk);
        end
        start = 1'b0; md_op = 3'd0;
        model_apply(3'd2, 32'hFFFF_FFFF, 32'd2);
        $display("ignore_run busy_cycles=%0d HI=%08h LO=%08h", cnt, HI, LO);
        n_checks++;
        if (cnt != 5 || HI !== ref_hi || LO !== ref_lo) begin
            n_fail++;
            $display("FAIL ignore_in_run: cycles=%0d HI=%08h LO=%08h required 5 HI=%08h LO=%08h",
                     cnt, HI, LO, ref_hi, ref_lo);
        end
        @(negedge clk);
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start_ran: Busy=%0d required 0", Busy);
        end
    endtask

    task automatic test_async_reset();
        int cnt; bit held;
        mt_op(3'd5, 32'h1111_2222, 1'b0); model_apply(3'd5, 32'h1111_2222, 32'd0);
        start = 1'b1; md_op = 3'd3; D1 = 32'd1000; D2 = 32'd3;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        ref_hi = 32'd0; ref_lo = 32'd0;
        $display("async_reset mid-div Busy=%0d HI=%08h LO=%08h", Busy, HI, LO);
        n_checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: Busy=%0d HI=%08h LO=%08h required 0/0/0", Busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(3'd1, 32'd12345, 32'hFFFF_FFF0, cnt, held);
        model_apply(3'd1, 32'd12345, 32'hFFFF_FFF0);
        n_checks++;
        if (cnt != 5 || HI !== ref_hi || LO !== ref_lo) begin
            n_fail++;
            $display("FAIL mult_after_reset: cycles=%0d HI=%08h LO=%08h required 5 HI=%08h LO=%08h",
                     cnt, HI, LO, ref_hi, ref_lo);
        end
    endtask

    task automatic test_back_to_back();
        int cnt; bit held;
        run_op(3'd3, 32'hFFFF_FF00, 32'd7, cnt, held);
        model_apply(3'd3, 32'hFFFF_FF00, 32'd7);
        n_checks++;
        if (HI !== ref_hi || LO !== ref_lo) begin
            n_fail++;
            $display("FAIL b2b_div: HI=%08h LO=%08h required HI=%08h LO=%08h", HI, LO, ref_hi, ref_lo);
        end
        run_op(3'd1, 32'h0001_0003, 32'h7000_0001, cnt, held);
        n_checks++;
        if (cnt != 5 || !held) begin
            n_fail++;
            $display("FAIL b2b_mult_timing: cycles=%0d held=%0d required 5/1", cnt, held);
        end
        model_apply(3'd1, 32'h0001_0003, 32'h7000_0001);
        n_checks++;
        if (HI !== ref_hi || LO !== ref_lo) begin
            n_fail++;
            $display("FAIL b2b_mult: HI=%08h LO=%08h required HI=%08h LO=%08h", HI, LO, ref_hi, ref_lo);
        end
    endtask

    task automatic test_random();
        int cnt; bit held; logic [2:0] op; logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            if (op >= 3'd5) begin
                mt_op(op, a, 1'b0);
                cnt = 0;
            end else begin
                run_op(op, a, b, cnt, held);
            end
            model_apply(op, a, b);
            n_checks++;
            if (HI !== ref_hi || LO !== ref_lo || (op <= 3'd4 && cnt != exp_cycles(op))) begin
                n_fail++;
                $display("FAIL random op%0d a=%08h b=%08h: HI=%08h LO=%08h cycles=%0d required HI=%08h LO=%08h",
                         op, a, b, HI, LO, cnt, ref_hi, ref_lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith(3'd1, 32'hFFFF_FFFF, 32'd2, 4);
        test_arith(3'd2, 32'hFFFF_FFFF, 32'd2, 4);
        test_arith(3'd3, 32'hFFFF_FFF9, 32'd2, 4);
        test_arith(3'd4, 32'd7, 32'd2, 4);
        test_div_zero();
        test_flush();
        test_ignore_run();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
